fpu_addsub: RTL and testbench

FPU_ADDSUB -- requirements
Module: fpu_addsub

---
 rtl/fpu_pkg.sv | 30 +++
 rtl/fpu_lzc.sv | 18 +
 rtl/fpu_addsub.sv | 246 ++++++++++++++++++++++++
 tb/tb_fpu_addsub.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types for the floating-point add/subtract unit.
package fpu_pkg;

  // One-hot result status; ST_NONE until the first result is produced.
  typedef enum logic [3:0] {
    ST_NONE      = 4'b0000,
    ST_EXACT     = 4'b0001,
    ST_OVERFLOW  = 4'b0010,
    ST_UNDERFLOW = 4'b0100,
    ST_INEXACT   = 4'b1000
  } status_e;

  // Fixed-latency operation sequence.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_OPERATE,
    S_NORMALIZE,
    S_ROUND,
    S_OUTPUT
  } state_e;

  // Guard, round and sticky bits below the mantissa LSB.
  typedef struct packed {
    logic g;
    logic r;
    logic s;
  } grs_t;

endpackage

// File: rtl/fpu_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fpu_lzc #(
  parameter int unsigned WIDTH = 23,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  // Scan upward so the most significant set bit determines the count.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_addsub.sv
// Multi-cycle floating-point adder/subtractor, round-to-nearest-even, no subnormals.
module fpu_addsub
  import fpu_pkg::*;
#(
  parameter  int unsigned EXP_W = 10,
  parameter  int unsigned MAN_W = 21,
  localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
  input  logic         clock_100KHz,
  input  logic         reset,
  input  logic         start_in,
  input  logic         op_sub_in,
  input  logic [W-1:0] op_A_in,
  input  logic [W-1:0] op_B_in,
  output logic         busy_out,
  output logic         done_out,
  output logic [W-1:0] data_out,
  output logic [3:0]   status_out
);

  localparam int unsigned BIAS    = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned EXP_INF = 2 * BIAS + 1;
  localparam int unsigned XW      = MAN_W + 4;   // hidden + mantissa + G/R/S
  localparam int unsigned SW      = XW + 1;      // plus carry-out
  localparam int unsigned LZ_W    = MAN_W + 2;   // hidden + mantissa + G
  localparam int unsigned LC_W    = $clog2(LZ_W + 1);
  localparam int unsigned EW      = EXP_W + 8;   // signed working exponent

  state_e state_q, state_d;

  logic [W-1:0]         a_q, b_q;
  logic                 sign_q, sub_q;
  logic [EXP_W-1:0]     exp_q;
  logic [XW-1:0]        big_q, small_q;
  logic                 spec_q;
  logic [W-1:0]         spec_res_q;
  status_e              spec_st_q;
  logic [SW-1:0]        sum_q;
  logic [XW-1:0]        norm_q;
  logic signed [EW-1:0] nexp_q;
  logic                 zero_q;

  // Align-stage combinational signals
  logic [EXP_W-1:0] exp_a, exp_b, hi_exp, lo_exp, diff;
  logic [MAN_W-1:0] hi_man, lo_man;
  logic             swap, lost, a_inf, b_inf, a_zero, b_zero;
  logic [XW-1:0]    lo_vec, shifted;
  logic             sign_c, sub_c, spec_c;
  logic [XW-1:0]    big_c, small_c;
  logic [W-1:0]     spec_res_c;
  status_e          spec_st_c;

  // Operate / normalize / round combinational signals
  logic [SW-1:0]        sum_c;
  logic [LC_W-1:0]      lz;
  logic signed [EW-1:0] exp_ext, nexp_c, fexp;
  logic [XW-1:0]        norm_c;
  logic                 zero_c, round_up, inexact;
  grs_t                 grs;
  logic [MAN_W+1:0]     mant_r;
  logic [MAN_W-1:0]     man_f;
  logic [W-1:0]         res_c;
  status_e              st_c;

  // State register
  always_ff @(posedge clock_100KHz or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: one step per clock once started
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start_in) state_d = S_ALIGN;
      S_ALIGN:     state_d = S_OPERATE;
      S_OPERATE:   state_d = S_NORMALIZE;
      S_NORMALIZE: state_d = S_ROUND;
      S_ROUND:     state_d = S_OUTPUT;
      S_OUTPUT:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Order operands by magnitude, shift the smaller with sticky, detect specials
  always_comb begin
    exp_a   = a_q[W-2:MAN_W];
    exp_b   = b_q[W-2:MAN_W];
    swap    = (b_q[W-2:0] > a_q[W-2:0]);
    hi_exp  = swap ? exp_b : exp_a;
    lo_exp  = swap ? exp_a : exp_b;
    hi_man  = swap ? b_q[MAN_W-1:0] : a_q[MAN_W-1:0];
    lo_man  = swap ? a_q[MAN_W-1:0] : b_q[MAN_W-1:0];
    sign_c  = swap ? b_q[W-1] : a_q[W-1];
    sub_c   = a_q[W-1] ^ b_q[W-1];
    diff    = hi_exp - lo_exp;
    lo_vec  = {1'b1, lo_man, 3'b000};
    shifted = lo_vec >> diff;
    lost    = ((shifted << diff) != lo_vec);
    if (32'(diff) >= XW) small_c = XW'(1);
    else                 small_c = shifted | XW'(lost);
    big_c   = {1'b1, hi_man, 3'b000};

    a_inf      = (exp_a == {EXP_W{1'b1}});
    b_inf      = (exp_b == {EXP_W{1'b1}});
    a_zero     = (exp_a == '0);
    b_zero     = (exp_b == '0);
    spec_c     = 1'b1;
    spec_res_c = '0;
    spec_st_c  = ST_EXACT;
    if (a_inf && b_inf) begin
      spec_res_c = {a_q[W-1] & b_q[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_st_c  = ST_OVERFLOW;
    end else if (a_inf) begin
      spec_res_c = {a_q[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_st_c  = ST_OVERFLOW;
    end else if (b_inf) begin
      spec_res_c = {b_q[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_st_c  = ST_OVERFLOW;
    end else if (a_zero && b_zero) begin
      spec_res_c = '0;
    end else if (a_zero) begin
      spec_res_c = b_q;
    end else if (b_zero) begin
      spec_res_c = a_q;
    end else begin
      spec_c = 1'b0;
    end
  end

  // Magnitude add or subtract (larger minus smaller, never negative)
  always_comb begin
    sum_c = sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                  : ({1'b0, big_q} + {1'b0, small_q});
  end

  fpu_lzc #(
    .WIDTH(LZ_W),
    .CNT_W(LC_W)
  ) u_lzc (
    .data (sum_q[XW-1:2]),
    .count(lz)
  );

  // Renormalize: carry-out shifts right, leading zeros shift left
  always_comb begin
    exp_ext = $signed(EW'(exp_q));
    norm_c  = sum_q[XW-1:0];
    nexp_c  = exp_ext;
    zero_c  = 1'b0;
    if (sum_q[XW]) begin
      norm_c = {sum_q[XW:2], sum_q[1] | sum_q[0]};
      nexp_c = exp_ext + EW'(1);
    end else if (sum_q == '0) begin
      zero_c = 1'b1;
    end else begin
      norm_c = sum_q[XW-1:0] << lz;
      nexp_c = exp_ext - $signed(EW'(lz));
    end
  end

  // Round to nearest even, then classify the final result
  always_comb begin
    grs      = grs_t'(norm_q[2:0]);
    round_up = grs.g & (grs.r | grs.s | norm_q[3]);
    inexact  = grs.g | grs.r | grs.s;
    mant_r   = (MAN_W+2)'(norm_q[XW-1:3]) + (MAN_W+2)'(round_up);
    if (mant_r[MAN_W+1]) begin
      man_f = mant_r[MAN_W:1];
      fexp  = nexp_q + EW'(1);
    end else begin
      man_f = mant_r[MAN_W-1:0];
      fexp  = nexp_q;
    end
    res_c = '0;
    st_c  = ST_EXACT;
    if (spec_q) begin
      res_c = spec_res_q;
      st_c  = spec_st_q;
    end else if (zero_q) begin
      res_c = '0;
      st_c  = ST_EXACT;
    end else if (fexp >= $signed(EW'(EXP_INF))) begin
      res_c = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      st_c  = ST_OVERFLOW;
    end else if (fexp[EW-1] || (fexp == '0)) begin
      res_c = '0;
      st_c  = ST_UNDERFLOW;
    end else begin
      res_c = {sign_q, fexp[EXP_W-1:0], man_f};
      st_c  = inexact ? ST_INEXACT : ST_EXACT;
    end
  end

  // Per-stage datapath registers and registered outputs
  always_ff @(posedge clock_100KHz or negedge reset) begin
    if (!reset) begin
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      sub_q      <= 1'b0;
      exp_q      <= '0;
      big_q      <= '0;
      small_q    <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_st_q  <= ST_NONE;
      sum_q      <= '0;
      norm_q     <= '0;
      nexp_q     <= '0;
      zero_q     <= 1'b0;
      data_out   <= '0;
      status_out <= '0;
      busy_out   <= 1'b0;
      done_out   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start_in) begin
        a_q <= op_A_in;
        b_q <= {op_B_in[W-1] ^ op_sub_in, op_B_in[W-2:0]};
      end
      if (state_q == S_ALIGN) begin
        sign_q     <= sign_c;
        sub_q      <= sub_c;
        exp_q      <= hi_exp;
        big_q      <= big_c;
        small_q    <= small_c;
        spec_q     <= spec_c;
        spec_res_q <= spec_res_c;
        spec_st_q  <= spec_st_c;
      end
      if (state_q == S_OPERATE) sum_q <= sum_c;
      if (state_q == S_NORMALIZE) begin
        norm_q <= norm_c;
        nexp_q <= nexp_c;
        zero_q <= zero_c;
      end
      if (state_q == S_ROUND) begin
        data_out   <= res_c;
        status_out <= st_c;
      end
      busy_out <= (state_d != S_IDLE);
      done_out <= (state_d == S_OUTPUT);
    end
  end

endmodule

// File: tb/tb_fpu_addsub.sv
// Directed-vector bench for fpu_addsub at EXP_W=10, MAN_W=21.
module tb_fpu_addsub;

  logic        clock_100KHz = 1'b0;
  logic        reset;
  logic        start_in;
  logic        op_sub_in;
  logic [31:0] op_A_in, op_B_in;
  logic        busy_out, done_out;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic [3:0]  st;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  always #5 clock_100KHz = ~clock_100KHz;

  fpu_addsub #(.EXP_W(10), .MAN_W(21)) dut (
    .clock_100KHz(clock_100KHz),
    .reset       (reset),
    .start_in    (start_in),
    .op_sub_in   (op_sub_in),
    .op_A_in     (op_A_in),
    .op_B_in     (op_B_in),
    .busy_out    (busy_out),
    .done_out    (done_out),
    .data_out    (data_out),
    .status_out  (status_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Issue one operation; lat counts rising edges including the capture edge.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, output logic [31:0] d, output logic [3:0] st,
                        output int lat);
    @(negedge clock_100KHz);
    op_A_in = a; op_B_in = b; op_sub_in = sub; start_in = 1'b1;
    @(posedge clock_100KHz); #1;
    start_in  = 1'b0;
    op_A_in   = $urandom;
    op_B_in   = $urandom;
    op_sub_in = ~sub;
    chk({tag, " busy"}, 32'(busy_out), 32'd1);
    lat = -1; d = '0; st = '0;
    for (int i = 2; i <= 12; i++) begin
      @(posedge clock_100KHz); #1;
      if (i == 2) start_in = 1'b1;
      if (i == 3) start_in = 1'b0;
      if (done_out) begin
        lat = i; d = data_out; st = status_out;
        break;
      end
    end
    start_in = 1'b0;
    @(posedge clock_100KHz); #1;
    chk({tag, " done pulse"}, 32'(done_out), 32'd0);
    chk({tag, " busy clear"}, 32'(busy_out), 32'd0);
    chk({tag, " hold"}, data_out, d);
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  st;
    int          lat;
    bit          seen_done;

    vecs[0]  = '{32'h3FE00000, 32'h3FE00000, 1'b0, 32'h40000000, 4'b0001}; // 1+1
    vecs[1]  = '{32'h3FE00000, 32'h3FE00000, 1'b1, 32'h00000000, 4'b0001}; // 1-1
    vecs[2]  = '{32'h7FDFFFFF, 32'h7FDFFFFF, 1'b0, 32'h7FE00000, 4'b0010}; // overflow
    vecs[3]  = '{32'h3FE00000, 32'h3D200000, 1'b0, 32'h3FE00000, 4'b1000}; // tie, even
    vecs[4]  = '{32'h00300000, 32'h00200000, 1'b1, 32'h00000000, 4'b0100}; // underflow
    vecs[5]  = '{32'h3FE00001, 32'h3D200000, 1'b0, 32'h3FE00002, 4'b1000}; // tie, odd up
    vecs[6]  = '{32'h7FE00000, 32'h3FE00000, 1'b0, 32'h7FE00000, 4'b0010}; // +inf+1
    vecs[7]  = '{32'h7FE00000, 32'hFFE00000, 1'b0, 32'h7FE00000, 4'b0010}; // +inf+-inf
    vecs[8]  = '{32'hFFE00000, 32'h3FE00000, 1'b0, 32'hFFE00000, 4'b0010}; // -inf+1
    vecs[9]  = '{32'h00000000, 32'h40100000, 1'b0, 32'h40100000, 4'b0001}; // 0+3
    vecs[10] = '{32'hC0100000, 32'h00000000, 1'b1, 32'hC0100000, 4'b0001}; // -3-0
    vecs[11] = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0001}; // 0+-0
    vecs[12] = '{32'h3FE00000, 32'h3FC00000, 1'b1, 32'h3FC00000, 4'b0001}; // 1-0.5
    vecs[13] = '{32'h40000000, 32'hC0100000, 1'b0, 32'hBFE00000, 4'b0001}; // 2+-3
    vecs[14] = '{32'h3FE00000, 32'h3C000000, 1'b0, 32'h3FE00000, 4'b1000}; // sticky only
    vecs[15] = '{32'h3FE00000, 32'h3C000000, 1'b1, 32'h3FE00000, 4'b1000}; // 1-tiny
    vecs[16] = '{32'h3FE00001, 32'h3FE00000, 1'b0, 32'h40000000, 4'b1000}; // carry, tie even
    vecs[17] = '{32'h3FE00003, 32'h3FE00000, 1'b0, 32'h40000002, 4'b1000}; // carry, tie up

    reset = 1'b0; start_in = 1'b0; op_sub_in = 1'b0;
    op_A_in = '0; op_B_in = '0;
    #12;
    chk("reset data", data_out, 32'h0);
    chk("reset status", 32'(status_out), 32'h0);
    chk("reset busy", 32'(busy_out), 32'h0);
    chk("reset done", 32'(done_out), 32'h0);
    @(negedge clock_100KHz);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      run_op(tag, vecs[i].a, vecs[i].b, vecs[i].sub, d, st, lat);
      chk({tag, " data"}, d, vecs[i].res);
      chk({tag, " status"}, 32'(st), 32'(vecs[i].st));
      chk({tag, " latency"}, 32'(lat), 32'd5);
    end

    // Abort mid-operation with reset while in NORMALIZE
    @(negedge clock_100KHz);
    op_A_in = 32'h3FE00000; op_B_in = 32'h3FE00000; op_sub_in = 1'b0; start_in = 1'b1;
    @(posedge clock_100KHz); #1;
    start_in = 1'b0;
    @(posedge clock_100KHz); #1;
    @(posedge clock_100KHz); #1;
    reset = 1'b0;
    #1;
    chk("abort data", data_out, 32'h0);
    chk("abort status", 32'(status_out), 32'h0);
    chk("abort busy", 32'(busy_out), 32'h0);
    chk("abort done", 32'(done_out), 32'h0);
    @(negedge clock_100KHz);
    reset = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock_100KHz); #1;
      if (done_out || busy_out) seen_done = 1'b1;
    end
    chk("abort no done", 32'(seen_done), 32'd0);
    run_op("after abort", 32'h3FE00000, 32'h3FE00000, 1'b0, d, st, lat);
    chk("after abort data", d, 32'h40000000);
    chk("after abort status", 32'(st), 32'h1);
    chk("after abort latency", 32'(lat), 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
